// File: rtl/lcd_scan_alarm_driver.sv
// lcd_scan_alarm_driver: multiplexed BCD display scanner with alarm ring/blink control
//   clk          - rising-edge clock
//   reset        - asynchronous active-low reset
//   current_time - current time, BCD, digit 0 in the low nibble
//   alarm_time   - stored alarm time, BCD
//   key_time     - keypad entry buffer, BCD
//   show_a       - display alarm_time (highest priority)
//   show_key     - display key_time
//   alarm_en     - alarm armed
//   alarm_stop   - level request to stop ringing
//   digit_sel    - registered one-hot digit strobe
//   seg_data     - registered ASCII code of the active digit (blank while blinking)
//   sound_a      - registered alarm sounder
module lcd_scan_alarm_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_DIV    = 25000,
    parameter int ALARM_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] current_time,
    input  logic [4*DIGITS-1:0] alarm_time,
    input  logic [4*DIGITS-1:0] key_time,
    input  logic                show_a,
    input  logic                show_key,
    input  logic                alarm_en,
    input  logic                alarm_stop,
    output logic [DIGITS-1:0]   digit_sel,
    output logic [7:0]          seg_data,
    output logic                sound_a
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int BW = $clog2(BLINK_DIV);
    localparam int RW = ALARM_CYCLES > 1 ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RINGING = 1'b1;

    logic [PW-1:0]       presc, presc_n;
    logic [IW-1:0]       idx, idx_n;
    logic [BW-1:0]       blink_cnt, blink_n;
    logic [RW-1:0]       ring_cnt, ring_n;
    logic [0:0]          state, state_n;
    logic                phase, phase_n, match, match_d, rise, scan_tc, blink_tc, stay;
    logic [4*DIGITS-1:0] src;
    logic [3:0]          nib;
    logic [7:0]          seg_n;

    // Output registers are loaded from next-state values so digit_sel,
    // seg_data and sound_a always agree with the internal state.
    always_comb begin
        src      = show_a ? alarm_time : show_key ? key_time : current_time;
        scan_tc  = presc == PW'(SCAN_DIV - 1);
        presc_n  = scan_tc ? '0 : presc + 1'b1;
        idx_n    = !scan_tc ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
        nib      = src[{idx_n, 2'b00} +: 4];
        match    = alarm_en && (current_time == alarm_time);
        rise     = match && !match_d;
        state_n  = state == IDLE
                 ? ((rise && !alarm_stop) ? RINGING : IDLE)
                 : ((alarm_stop || !alarm_en || ring_cnt == RW'(ALARM_CYCLES - 1)) ? IDLE : RINGING);
        // Counters and phase restart on every entry into RINGING.
        stay     = state == RINGING && state_n == RINGING;
        ring_n   = stay ? ring_cnt + 1'b1 : '0;
        blink_tc = blink_cnt == BW'(BLINK_DIV - 1);
        blink_n  = (stay && !blink_tc) ? blink_cnt + 1'b1 : '0;
        phase_n  = stay && (phase ^ blink_tc);
        seg_n    = phase_n ? 8'h20 : nib > 4'd9 ? 8'h45 : 8'h30 + {4'h0, nib};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            idx       <= '0;
            digit_sel <= DIGITS'(1);
            seg_data  <= 8'h20;
            state     <= IDLE;
            sound_a   <= 1'b0;
            ring_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            match_d   <= 1'b1;
        end else begin
            presc     <= presc_n;
            idx       <= idx_n;
            digit_sel <= DIGITS'(1) << idx_n;
            seg_data  <= seg_n;
            state     <= state_n;
            sound_a   <= state_n == RINGING;
            ring_cnt  <= ring_n;
            blink_cnt <= blink_n;
            phase     <= phase_n;
            match_d   <= match;
        end
    end
endmodule

// File: tb/tb_lcd_scan_alarm_driver.sv
// tb_lcd_scan_alarm_driver: directed self-checking bench for lcd_scan_alarm_driver
module tb_lcd_scan_alarm_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] current_time = 16'h1234;
    logic [15:0] alarm_time = 16'h0000;
    logic [15:0] key_time = 16'h0000;
    logic        show_a = 1'b0, show_key = 1'b0, alarm_en = 1'b0, alarm_stop = 1'b0;
    logic [3:0]  digit_sel;
    logic [7:0]  seg_data;
    logic        sound_a;
    int          total = 0;
    int          bad = 0;

    lcd_scan_alarm_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(6), .ALARM_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .current_time(current_time), .alarm_time(alarm_time),
        .key_time(key_time), .show_a(show_a), .show_key(show_key), .alarm_en(alarm_en),
        .alarm_stop(alarm_stop), .digit_sel(digit_sel), .seg_data(seg_data), .sound_a(sound_a)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sel(input logic [3:0] e);
        int c = 0;
        step(1);
        while (digit_sel !== e && c < 20) begin
            step(1);
            c++;
        end
        chk("wait_sel", {28'h0, digit_sel}, {28'h0, e});
    endtask

    initial begin
        logic seen;
        #2 reset = 1'b0;
        #1;
        chk("rst_sel", {28'h0, digit_sel}, 32'h1);
        chk("rst_seg", {24'h0, seg_data}, 32'h20);
        chk("rst_snd", {31'h0, sound_a}, 32'h0);
        #24 reset = 1'b1;
        // After release edge n: prescaler = n%4, digit index = (n/4)%4.
        for (int n = 1; n <= 17; n++) begin
            step(1);
            chk("scan_sel", {28'h0, digit_sel}, 32'h1 << ((n / 4) % 4));
            chk("scan_seg", {24'h0, seg_data}, 32'h34 - ((n / 4) % 4));
        end
        show_a = 1'b1; show_key = 1'b1; alarm_time = 16'h0730; key_time = 16'h9999;
        wait_sel(4'b0001);
        chk("prio_d0", {24'h0, seg_data}, 32'h30);
        wait_sel(4'b0010);
        chk("prio_d1", {24'h0, seg_data}, 32'h33);
        show_a = 1'b0;
        wait_sel(4'b0001);
        chk("key_d0", {24'h0, seg_data}, 32'h39);
        show_key = 1'b0; current_time = 16'h00A0;
        wait_sel(4'b0001);
        chk("bcd_d0", {24'h0, seg_data}, 32'h30);
        wait_sel(4'b0010);
        chk("bcd_d1", {24'h0, seg_data}, 32'h45);
        alarm_en = 1'b1; alarm_time = 16'h0600; current_time = 16'h0559;
        step(2);
        chk("pre_ring", {31'h0, sound_a}, 32'h0);
        current_time = 16'h0600;
        step(1);
        chk("ring_e0", {31'h0, sound_a}, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("ring_hold", {31'h0, sound_a}, 32'h1);
            if (k == 5) chk("blink_off", {31'h0, seg_data == 8'h20}, 32'h0);
            if (k == 6) chk("blink_on", {24'h0, seg_data}, 32'h20);
        end
        step(1);
        chk("timeout", {31'h0, sound_a}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            seen = seen | sound_a;
        end
        chk("no_rering", {31'h0, seen}, 32'h0);
        current_time = 16'h0559;
        step(2);
        current_time = 16'h0600;
        step(1);
        chk("stop_ring", {31'h0, sound_a}, 32'h1);
        step(2);
        alarm_stop = 1'b1;
        step(1);
        chk("stop_drop", {31'h0, sound_a}, 32'h0);
        alarm_stop = 1'b0;
        step(3);
        chk("stop_stay", {31'h0, sound_a}, 32'h0);
        current_time = 16'h0559;
        step(2);
        current_time = 16'h0600; alarm_stop = 1'b1;
        step(1);
        chk("stop_prio", {31'h0, sound_a}, 32'h0);
        alarm_stop = 1'b0;
        step(3);
        chk("stop_prio2", {31'h0, sound_a}, 32'h0);
        current_time = 16'h0559;
        step(2);
        current_time = 16'h0600;
        step(1);
        chk("en_ring", {31'h0, sound_a}, 32'h1);
        alarm_en = 1'b0;
        step(1);
        chk("en_drop", {31'h0, sound_a}, 32'h0);
        alarm_en = 1'b1; current_time = 16'h0559;
        step(2);
        current_time = 16'h0600;
        step(3);
        chk("rst_ring", {31'h0, sound_a}, 32'h1);
        reset = 1'b0;
        #1;
        chk("arst_snd", {31'h0, sound_a}, 32'h0);
        chk("arst_sel", {28'h0, digit_sel}, 32'h1);
        chk("arst_seg", {24'h0, seg_data}, 32'h20);
        step(2);
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            seen = seen | sound_a;
        end
        chk("rel_quiet", {31'h0, seen}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_scan_alarm_driver.md
LCD_SCAN_ALARM_DRIVER -- requirements
Module: lcd_scan_alarm_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits displayed and compared.
REQ-002 SHALL have parameter SCAN_DIV, default 1000: clocks per digit-scan step (>=2).
REQ-003 SHALL have parameter BLINK_DIV, default 25000: clocks per blink half-period (>=2).
REQ-004 SHALL have parameter ALARM_CYCLES, default 500000: maximum clocks sound_a stays asserted (>=1).
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port current_time, input, 4*DIGITS: current time in BCD; digit 0 is the least significant nibble.
REQ-008 SHALL have port alarm_time, input, 4*DIGITS: stored alarm time in BCD.
REQ-009 SHALL have port key_time, input, 4*DIGITS: keypad entry buffer in BCD.
REQ-010 SHALL have port show_a, input, 1: display alarm_time.
REQ-011 SHALL have port show_key, input, 1: display key_time.
REQ-012 SHALL have port alarm_en, input, 1: alarm armed.
REQ-013 SHALL have port alarm_stop, input, 1: stop ringing; level, sampled each clock.
REQ-014 SHALL have port digit_sel, output, DIGITS: one-hot active digit strobe.
REQ-015 SHALL have port seg_data, output, 8: ASCII code for the active digit.
REQ-016 SHALL have port sound_a, output, 1: alarm sounding.

Function
REQ-017 SHALL select the display source with fixed priority: show_a gives alarm_time; else show_key gives key_time; else current_time. Selection is evaluated every clock.
REQ-018 SHALL run a scan prescaler that counts 0..SCAN_DIV-1; on terminal count it wraps to 0 and the digit index advances by 1, wrapping DIGITS-1 to 0.
REQ-019 SHALL drive digit_sel as a registered one-hot of the digit index, bit i set for index i.
REQ-020 SHALL register seg_data in the same clock as digit_sel, so both change in the same cycle with zero skew.
REQ-021 SHALL encode seg_data from the selected nibble as follows: 0-9 map to 8'h30+d; 10-15 map to 8'h45 ('E').
REQ-022 SHALL compute match as alarm_en AND (current_time == alarm_time) over all 4*DIGITS bits.
REQ-023 SHALL register match into match_d every clock.
REQ-024 SHALL implement a two-state FSM with states IDLE and RINGING.
REQ-025 SHALL move IDLE to RINGING on match AND NOT match_d AND NOT alarm_stop. On entry the ring counter loads 0 and the blink phase loads 0.
REQ-026 SHALL move RINGING to IDLE on the first of: alarm_stop=1, alarm_en=0, or the ring counter reaching ALARM_CYCLES-1. The exit happens on the clock edge that samples the condition.
REQ-027 SHALL drive sound_a registered, high exactly while the state is RINGING. Latency from the match edge to sound_a=1 is 1 clock.
REQ-028 SHALL NOT re-ring while match stays high after a stop or timeout; a new ring requires match to fall and rise again.
REQ-029 SHALL give alarm_stop priority over a simultaneous match rising edge, so the FSM stays in IDLE.
REQ-030 SHALL, while RINGING, toggle the blink phase every BLINK_DIV clocks. When phase=1, seg_data SHALL be 8'h20 (blank) and digit_sel keeps scanning.
REQ-031 SHALL size counters as $clog2 of their maximum value plus 1; no counter may overflow or wrap except as specified above.

Reset
REQ-032 SHALL, on reset=0, asynchronously clear the following: prescaler=0, digit index=0, digit_sel=1 (digit 0), seg_data=8'h20, state=IDLE, sound_a=0, ring counter=0, blink phase=0.
REQ-033 SHALL set match_d=1 on reset, so a match already present at reset release does not ring.
REQ-034 SHALL, if reset asserts while RINGING, drop sound_a immediately (asynchronously). After release the block stays IDLE until a fresh match rising edge.

Verification
REQ-035 Scan test: DIGITS=4, SCAN_DIV=4, current_time=16'h1234, no show_* inputs. Expect digit_sel 0001/'4'(8'h34), 0010/'3', 0100/'2', 1000/'1', each held 4 clocks, then wrap to 0001.
REQ-036 Priority test: show_a=1, show_key=1, alarm_time=16'h0730, key_time=16'h9999. Expect the digit-0 strobe to show 8'h30 and digit 1 to show 8'h33, i.e. alarm_time displayed.
REQ-037 Invalid BCD test: current_time=16'h00A0. Expect 8'h45 on digit 1.
REQ-038 Ring and timeout test: alarm_en=1, alarm_time=16'h0600, current_time steps 16'h0559 to 16'h0600. Expect sound_a=1 one clock later, held exactly ALARM_CYCLES clocks, then 0. No re-ring while current_time stays 16'h0600.
REQ-039 Stop test: while ringing, pulse alarm_stop=1 for 1 clock. Expect sound_a=0 on the next edge. Also drive alarm_stop=1 in the same cycle as a match rising edge and expect sound_a to stay 0.
REQ-040 Reset test: assert reset mid-ring. Expect sound_a=0 and digit_sel=0001 with no clock edge. Release reset with match=1 and expect sound_a to remain 0.
